// File: rtl/ddr_req_sched_if.sv
// Request/response and DDR-channel signal bundle for ddr_req_sched.
// slave: the scheduler; master: requesters plus DDR model.
interface ddr_req_sched_if;
  localparam int unsigned IDX_W  = 64;
  localparam int unsigned LINE_W = 512;

  logic              ic_req_valid;
  logic              ic_req_ready;
  logic [IDX_W-1:0]  ic_req_index;
  logic [LINE_W-1:0] ic_resp_data;
  logic              ic_resp_done;

  logic              dc_req_valid;
  logic              dc_req_ready;
  logic [IDX_W-1:0]  dc_req_index;
  logic              dc_req_write;
  logic [LINE_W-1:0] dc_req_wdata;
  logic [LINE_W-1:0] dc_req_wmask;
  logic [LINE_W-1:0] dc_resp_data;
  logic              dc_resp_done;

  logic              ddr_chip_enable;
  logic [IDX_W-1:0]  ddr_index;
  logic              ddr_write_enable;
  logic              ddr_burst_mode;
  logic [LINE_W-1:0] ddr_write_mask;
  logic [LINE_W-1:0] ddr_write_data;
  logic [LINE_W-1:0] ddr_read_data;
  logic              ddr_operation_done;
  logic              ddr_ready;

  logic              sched_timeout_err;

  modport slave (
    input  ic_req_valid, ic_req_index,
    output ic_req_ready, ic_resp_data, ic_resp_done,
    input  dc_req_valid, dc_req_index, dc_req_write, dc_req_wdata, dc_req_wmask,
    output dc_req_ready, dc_resp_data, dc_resp_done,
    output ddr_chip_enable, ddr_index, ddr_write_enable, ddr_burst_mode,
    output ddr_write_mask, ddr_write_data,
    input  ddr_read_data, ddr_operation_done, ddr_ready,
    output sched_timeout_err
  );

  modport master (
    output ic_req_valid, ic_req_index,
    input  ic_req_ready, ic_resp_data, ic_resp_done,
    output dc_req_valid, dc_req_index, dc_req_write, dc_req_wdata, dc_req_wmask,
    input  dc_req_ready, dc_resp_data, dc_resp_done,
    input  ddr_chip_enable, ddr_index, ddr_write_enable, ddr_burst_mode,
    input  ddr_write_mask, ddr_write_data,
    output ddr_read_data, ddr_operation_done, ddr_ready,
    input  sched_timeout_err
  );
endinterface

// File: rtl/ddr_req_sched.sv
// Two-requester (icache/dcache) scheduler for a single DDR channel with
// bounded dcache priority and a completion watchdog.
module ddr_req_sched #(
  parameter int unsigned STARVE_LIMIT   = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic            clock,
  input logic            reset_n,
  ddr_req_sched_if.slave bus
);
  localparam int unsigned IDX_W  = 64;
  localparam int unsigned LINE_W = 512;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned WDOG_W = 16;
  localparam logic [CNT_W-1:0]  STARVE_MAX = CNT_W'(STARVE_LIMIT);
  localparam logic [WDOG_W-1:0] WDOG_LAST  = WDOG_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              w_grant_ic;
  logic              w_grant_dc;
  logic              w_chip_enable;
  logic              w_done_hit;
  logic              w_timeout_hit;
  logic              w_acc_write;
  logic [LINE_W-1:0] w_resp_line;

  logic              r_owner;
  logic [CNT_W-1:0]  r_starve_cnt;
  logic [WDOG_W-1:0] r_wdog;
  logic [IDX_W-1:0]  r_ddr_index;
  logic              r_ddr_write_enable;
  logic              r_ddr_burst_mode;
  logic [LINE_W-1:0] r_ddr_write_mask;
  logic [LINE_W-1:0] r_ddr_write_data;
  logic [LINE_W-1:0] r_ic_resp_data;
  logic [LINE_W-1:0] r_dc_resp_data;
  logic              r_ic_resp_done;
  logic              r_dc_resp_done;
  logic              r_timeout_err;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  // Arbitration, issue handshake and completion detection.
  always_comb begin
    w_next_state  = r_state;
    w_grant_ic    = 1'b0;
    w_grant_dc    = 1'b0;
    w_chip_enable = 1'b0;
    w_done_hit    = 1'b0;
    w_timeout_hit = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_grant_ic = bus.ic_req_valid & (~bus.dc_req_valid | (r_starve_cnt >= STARVE_MAX));
        w_grant_dc = bus.dc_req_valid & ~w_grant_ic;
        if (w_grant_ic || w_grant_dc) w_next_state = S_ISSUE;
      end
      S_ISSUE: begin
        if (bus.ddr_ready) begin
          w_chip_enable = 1'b1;
          w_next_state  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.ddr_operation_done) begin
          w_done_hit   = 1'b1;
          w_next_state = S_IDLE;
        end else if (r_wdog == WDOG_LAST) begin
          w_timeout_hit = 1'b1;
          w_next_state  = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign w_acc_write = w_grant_dc & bus.dc_req_write;
  assign w_resp_line = w_done_hit ? bus.ddr_read_data : '0;

  // Request latch, starvation counter, watchdog and response registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_owner            <= 1'b0;
      r_starve_cnt       <= '0;
      r_wdog             <= '0;
      r_ddr_index        <= '0;
      r_ddr_write_enable <= 1'b0;
      r_ddr_burst_mode   <= 1'b0;
      r_ddr_write_mask   <= '0;
      r_ddr_write_data   <= '0;
      r_ic_resp_data     <= '0;
      r_dc_resp_data     <= '0;
      r_ic_resp_done     <= 1'b0;
      r_dc_resp_done     <= 1'b0;
      r_timeout_err      <= 1'b0;
    end else begin
      r_ic_resp_done <= 1'b0;
      r_dc_resp_done <= 1'b0;

      if (w_grant_ic || w_grant_dc) begin
        r_owner            <= w_grant_dc;
        r_ddr_index        <= w_grant_dc ? bus.dc_req_index : bus.ic_req_index;
        r_ddr_write_enable <= w_acc_write;
        r_ddr_burst_mode   <= w_grant_ic;
        r_ddr_write_mask   <= w_acc_write ? bus.dc_req_wmask : '0;
        r_ddr_write_data   <= w_acc_write ? bus.dc_req_wdata : '0;
      end

      if (w_grant_ic) begin
        r_starve_cnt <= '0;
      end else if (w_grant_dc && bus.ic_req_valid && (r_starve_cnt < STARVE_MAX)) begin
        r_starve_cnt <= r_starve_cnt + CNT_W'(1);
      end

      if (w_chip_enable)          r_wdog <= '0;
      else if (r_state == S_WAIT) r_wdog <= r_wdog + WDOG_W'(1);

      if (w_done_hit || w_timeout_hit) begin
        if (r_owner) begin
          r_dc_resp_data <= w_resp_line;
          r_dc_resp_done <= 1'b1;
        end else begin
          r_ic_resp_data <= w_resp_line;
          r_ic_resp_done <= 1'b1;
        end
      end

      if (w_timeout_hit) r_timeout_err <= 1'b1;
    end
  end

  assign bus.ic_req_ready      = w_grant_ic;
  assign bus.dc_req_ready      = w_grant_dc;
  assign bus.ic_resp_data      = r_ic_resp_data;
  assign bus.ic_resp_done      = r_ic_resp_done;
  assign bus.dc_resp_data      = r_dc_resp_data;
  assign bus.dc_resp_done      = r_dc_resp_done;
  assign bus.ddr_chip_enable   = w_chip_enable;
  assign bus.ddr_index         = r_ddr_index;
  assign bus.ddr_write_enable  = r_ddr_write_enable;
  assign bus.ddr_burst_mode    = r_ddr_burst_mode;
  assign bus.ddr_write_mask    = r_ddr_write_mask;
  assign bus.ddr_write_data    = r_ddr_write_data;
  assign bus.sched_timeout_err = r_timeout_err;
endmodule

// File: tb/tb_ddr_req_sched.sv
// Directed bench for ddr_req_sched: single reads/writes, starvation order,
// ddr_ready stall, watchdog timeout and reset during an operation.
module tb_ddr_req_sched;
  localparam int unsigned LINE_W = 512;

  logic clock;
  logic reset_n;
  int   n_tests;
  int   n_fail;

  ddr_req_sched_if u_if ();

  ddr_req_sched #(
    .STARVE_LIMIT   (8),
    .TIMEOUT_CYCLES (16)
  ) u_dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (u_if.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  logic [LINE_W-1:0] pat_a5;
  logic [LINE_W-1:0] rd_line;
  logic              exp_dc;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    pat_a5  = {64{8'hA5}};
    reset_n = 1'b0;
    u_if.ic_req_valid       = 1'b0;
    u_if.ic_req_index       = '0;
    u_if.dc_req_valid       = 1'b0;
    u_if.dc_req_index       = '0;
    u_if.dc_req_write       = 1'b0;
    u_if.dc_req_wdata       = '0;
    u_if.dc_req_wmask       = '0;
    u_if.ddr_read_data      = '0;
    u_if.ddr_operation_done = 1'b0;
    u_if.ddr_ready          = 1'b1;

    // Reset values
    cyc(); settle();
    check("rst_index",   LINE_W'(u_if.ddr_index), '0);
    check("rst_we",      LINE_W'(u_if.ddr_write_enable), '0);
    check("rst_burst",   LINE_W'(u_if.ddr_burst_mode), '0);
    check("rst_ce",      LINE_W'(u_if.ddr_chip_enable), '0);
    check("rst_ic_done", LINE_W'(u_if.ic_resp_done), '0);
    check("rst_dc_data", u_if.dc_resp_data, '0);
    check("rst_err",     LINE_W'(u_if.sched_timeout_err), '0);
    cyc();
    reset_n = 1'b1;
    cyc();

    // Single icache read, done 5 cycles after chip enable
    u_if.ic_req_valid = 1'b1;
    u_if.ic_req_index = 64'h8000_0040;
    settle();
    check("ic_ready_T", LINE_W'(u_if.ic_req_ready), LINE_W'(1'b1));
    check("dc_ready_T", LINE_W'(u_if.dc_req_ready), '0);
    cyc();
    u_if.ic_req_valid = 1'b0;
    settle();
    check("ic_ce_T1",    LINE_W'(u_if.ddr_chip_enable), LINE_W'(1'b1));
    check("ic_burst",    LINE_W'(u_if.ddr_burst_mode), LINE_W'(1'b1));
    check("ic_we",       LINE_W'(u_if.ddr_write_enable), '0);
    check("ic_mask",     u_if.ddr_write_mask, '0);
    check("ic_index",    LINE_W'(u_if.ddr_index), LINE_W'(64'h8000_0040));
    for (int k = 2; k <= 5; k++) begin
      cyc(); settle();
      check("ic_ce_once", LINE_W'(u_if.ddr_chip_enable), '0);
    end
    cyc();
    rd_line = {16{32'hC0DE_0001}};
    u_if.ddr_read_data      = rd_line;
    u_if.ddr_operation_done = 1'b1;
    settle();
    check("ic_done_early", LINE_W'(u_if.ic_resp_done), '0);
    cyc();
    u_if.ddr_operation_done = 1'b0;
    u_if.ddr_read_data      = '0;
    settle();
    check("ic_done_T7", LINE_W'(u_if.ic_resp_done), LINE_W'(1'b1));
    check("ic_data_T7", u_if.ic_resp_data, rd_line);
    check("ic_dc_quiet", LINE_W'(u_if.dc_resp_done), '0);
    cyc(); settle();
    check("ic_done_pulse", LINE_W'(u_if.ic_resp_done), '0);
    check("ic_data_hold",  u_if.ic_resp_data, rd_line);

    // Dcache write-back; request inputs change after acceptance to prove latching
    u_if.dc_req_valid = 1'b1;
    u_if.dc_req_index = 64'h100;
    u_if.dc_req_write = 1'b1;
    u_if.dc_req_wdata = pat_a5;
    u_if.dc_req_wmask = '1;
    settle();
    check("wb_ready", LINE_W'(u_if.dc_req_ready), LINE_W'(1'b1));
    cyc();
    u_if.dc_req_valid = 1'b0;
    u_if.dc_req_wdata = '0;
    u_if.dc_req_wmask = '0;
    u_if.dc_req_write = 1'b0;
    settle();
    check("wb_ce",    LINE_W'(u_if.ddr_chip_enable), LINE_W'(1'b1));
    check("wb_we",    LINE_W'(u_if.ddr_write_enable), LINE_W'(1'b1));
    check("wb_burst", LINE_W'(u_if.ddr_burst_mode), '0);
    check("wb_data",  u_if.ddr_write_data, pat_a5);
    check("wb_mask",  u_if.ddr_write_mask, '1);
    check("wb_index", LINE_W'(u_if.ddr_index), LINE_W'(64'h100));
    cyc();
    u_if.ddr_operation_done = 1'b1;
    settle();
    check("wb_data_wait", u_if.ddr_write_data, pat_a5);
    check("wb_mask_wait", u_if.ddr_write_mask, '1);
    cyc();
    u_if.ddr_operation_done = 1'b0;
    settle();
    check("wb_dc_done", LINE_W'(u_if.dc_resp_done), LINE_W'(1'b1));
    check("wb_ic_done", LINE_W'(u_if.ic_resp_done), '0);
    check("wb_idle_keep", u_if.ddr_write_data, pat_a5);
    cyc(); settle();
    check("wb_dc_once", LINE_W'(u_if.dc_resp_done), '0);

    // Both requesters always valid: 8 dcache grants then 1 icache grant
    u_if.ic_req_valid = 1'b1;
    u_if.ic_req_index = 64'hA000;
    u_if.dc_req_valid = 1'b1;
    u_if.dc_req_index = 64'hB000;
    for (int g = 0; g < 18; g++) begin
      exp_dc = ((g % 9) != 8);
      settle();
      check("arb_dc", LINE_W'(u_if.dc_req_ready), LINE_W'(exp_dc));
      check("arb_ic", LINE_W'(u_if.ic_req_ready), LINE_W'(!exp_dc));
      cyc(); settle();
      check("arb_burst", LINE_W'(u_if.ddr_burst_mode), LINE_W'(!exp_dc));
      cyc();
      u_if.ddr_operation_done = 1'b1;
      cyc();
      u_if.ddr_operation_done = 1'b0;
    end
    u_if.ic_req_valid = 1'b0;
    u_if.dc_req_valid = 1'b0;
    cyc();

    // ddr_ready held low for 10 cycles after acceptance
    u_if.dc_req_valid = 1'b1;
    u_if.dc_req_index = 64'h200;
    u_if.dc_req_write = 1'b0;
    u_if.ddr_ready    = 1'b0;
    settle();
    check("stall_accept", LINE_W'(u_if.dc_req_ready), LINE_W'(1'b1));
    u_if.ic_req_valid = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cyc(); settle();
      check("stall_ce",    LINE_W'(u_if.ddr_chip_enable), '0);
      check("stall_ready", LINE_W'({u_if.ic_req_ready, u_if.dc_req_ready}), '0);
    end
    cyc();
    u_if.ddr_ready    = 1'b1;
    settle();
    check("stall_ce_go", LINE_W'(u_if.ddr_chip_enable), LINE_W'(1'b1));
    check("stall_we",    LINE_W'(u_if.ddr_write_enable), '0);
    check("stall_index", LINE_W'(u_if.ddr_index), LINE_W'(64'h200));
    u_if.ic_req_valid = 1'b0;
    u_if.dc_req_valid = 1'b0;
    cyc();
    rd_line = {8{64'h0123_4567_89AB_CDEF}};
    u_if.ddr_read_data      = rd_line;
    u_if.ddr_operation_done = 1'b1;
    cyc();
    u_if.ddr_operation_done = 1'b0;
    settle();
    check("stall_done", LINE_W'(u_if.dc_resp_done), LINE_W'(1'b1));
    check("stall_data", u_if.dc_resp_data, rd_line);

    // Watchdog: dcache read never completes (TIMEOUT_CYCLES = 16)
    cyc();
    u_if.dc_req_valid = 1'b1;
    u_if.dc_req_index = 64'h300;
    cyc();
    u_if.dc_req_valid = 1'b0;
    settle();
    check("to_ce", LINE_W'(u_if.ddr_chip_enable), LINE_W'(1'b1));
    for (int k = 1; k <= 16; k++) begin
      cyc(); settle();
      check("to_pending", LINE_W'({u_if.sched_timeout_err, u_if.dc_resp_done}), '0);
    end
    cyc(); settle();
    check("to_err",     LINE_W'(u_if.sched_timeout_err), LINE_W'(1'b1));
    check("to_dc_done", LINE_W'(u_if.dc_resp_done), LINE_W'(1'b1));
    check("to_dc_data", u_if.dc_resp_data, '0);
    check("to_ic_done", LINE_W'(u_if.ic_resp_done), '0);
    cyc();
    u_if.ddr_operation_done = 1'b1;
    cyc();
    u_if.ddr_operation_done = 1'b0;
    settle();
    check("spur_done", LINE_W'({u_if.ic_resp_done, u_if.dc_resp_done}), '0);
    check("spur_data", u_if.dc_resp_data, '0);
    check("err_sticky", LINE_W'(u_if.sched_timeout_err), LINE_W'(1'b1));

    // Reset asserted while in WAIT
    u_if.ic_req_valid = 1'b1;
    u_if.ic_req_index = 64'h400;
    cyc();
    u_if.ic_req_valid = 1'b0;
    cyc();
    reset_n = 1'b0;
    settle();
    check("rw_index", LINE_W'(u_if.ddr_index), '0);
    check("rw_burst", LINE_W'(u_if.ddr_burst_mode), '0);
    check("rw_err",   LINE_W'(u_if.sched_timeout_err), '0);
    check("rw_ic_data", u_if.ic_resp_data, '0);
    u_if.ddr_operation_done = 1'b1;
    cyc(); settle();
    check("rw_no_done", LINE_W'({u_if.ic_resp_done, u_if.dc_resp_done}), '0);
    u_if.ddr_operation_done = 1'b0;
    cyc();
    reset_n = 1'b1;
    cyc();
    u_if.dc_req_valid = 1'b1;
    u_if.dc_req_index = 64'h500;
    settle();
    check("rw_accept", LINE_W'(u_if.dc_req_ready), LINE_W'(1'b1));
    cyc();
    u_if.dc_req_valid = 1'b0;
    settle();
    check("rw_ce",    LINE_W'(u_if.ddr_chip_enable), LINE_W'(1'b1));
    check("rw_index2", LINE_W'(u_if.ddr_index), LINE_W'(64'h500));
    cyc();
    rd_line = {128{4'h9}};
    u_if.ddr_read_data      = rd_line;
    u_if.ddr_operation_done = 1'b1;
    cyc();
    u_if.ddr_operation_done = 1'b0;
    settle();
    check("rw_done", LINE_W'(u_if.dc_resp_done), LINE_W'(1'b1));
    check("rw_data", u_if.dc_resp_data, rd_line);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
